// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. Operands and borrow-in are latched on a
//   start pulse in IDLE; one difference bit is resolved per clock (LSB first)
//   through a single full-subtractor cell and a registered borrow flip-flop.
//   The parallel difference and status flags update together with a
//   one-cycle done pulse and then hold until the next result or reset.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE
//   a      in   minuend, sampled with start
//   b      in   subtrahend, sampled with start
//   bin    in   borrow-in, sampled with start
//   busy   out  high while a subtraction is in progress
//   done   out  one-cycle pulse when results become valid
//   diff   out  a - b - bin modulo 2^WIDTH
//   bout   out  final borrow-out (unsigned underflow)
//   ovf    out  signed two's-complement overflow
//   zero   out  diff == 0
//   d_bit  out  current serial difference bit, valid while busy

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             d_bit
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              br_q, br_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    // Full-subtractor cell on the current LSBs.
    logic              d;
    logic              br_next;
    logic [WIDTH-1:0]  res_shift;

    assign d         = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign res_shift = {d, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = StShift;
                end
            end
            StShift: begin
                res_d = res_shift;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    // Publish on the last shift so flags land in the same
                    // cycle as the done pulse.
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    ovf_d   = (a_msb_q != b_msb_q) && (d != a_msb_q);
                    zero_d  = (res_shift == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy  = (state_q == StShift);
    assign done  = (state_q == StDone);
    assign d_bit = busy & d;
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an
// arithmetic reference model.

module tb_serial_subtractor;

    localparam int unsigned Width = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [Width-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;
    logic             d_bit;

    int errors = 0;
    int checks = 0;

    // Last published results, used to check that outputs hold.
    logic [Width-1:0] prev_diff;
    logic             prev_bout;
    logic             prev_ovf;
    logic             prev_zero;

    serial_subtractor #(
        .WIDTH(Width)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .ovf  (ovf),
        .zero (zero),
        .d_bit(d_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic; ovf from the sign rule on operand and result MSBs.
    function automatic void model(input logic [Width-1:0] ma, input logic [Width-1:0] mb,
                                  input logic mbin, output logic [Width-1:0] md,
                                  output logic mbout, output logic mo, output logic mz);
        int t;
        t     = int'(ma) - int'(mb) - int'(mbin);
        md    = t[Width-1:0];
        mbout = (t < 0);
        mo    = (ma[Width-1] != mb[Width-1]) && (md[Width-1] != ma[Width-1]);
        mz    = (md == '0);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, " busy"},  32'(busy),  32'd0);
        check({tag, " done"},  32'(done),  32'd0);
        check({tag, " diff"},  32'(diff),  32'd0);
        check({tag, " bout"},  32'(bout),  32'd0);
        check({tag, " ovf"},   32'(ovf),   32'd0);
        check({tag, " zero"},  32'(zero),  32'd0);
        check({tag, " d_bit"}, 32'(d_bit), 32'd0);
    endtask

    // Called at a negedge with the DUT idle. inject_at: busy-cycle index at
    // which to pulse start with junk operands (or reset when do_rst).
    task automatic run_op(input logic [Width-1:0] ta, input logic [Width-1:0] tb,
                          input logic tbin, input int inject_at, input bit do_rst);
        logic [Width-1:0] ed;
        logic             eb;
        logic             eo;
        logic             ez;
        model(ta, tb, tbin, ed, eb, eo, ez);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(Width); i++) begin
            check("busy", 32'(busy), 32'd1);
            check("done early", 32'(done), 32'd0);
            check("d_bit", 32'(d_bit), 32'(ed[i]));
            check("diff hold", 32'(diff), 32'(prev_diff));
            check("bout hold", 32'(bout), 32'(prev_bout));
            if (i == inject_at && do_rst) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_outputs_zero("after rst");
                prev_diff = '0;
                prev_bout = 1'b0;
                prev_ovf  = 1'b0;
                prev_zero = 1'b0;
                for (int j = 0; j < int'(Width) + 2; j++) begin
                    @(negedge clk);
                    check("no done after rst", 32'(done), 32'd0);
                    check("idle after rst", 32'(busy), 32'd0);
                end
                return;
            end
            if (i == inject_at) begin
                a     = ~ta;
                b     = ta ^ 8'h5a;
                bin   = ~tbin;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done", 32'(done), 32'd1);
        check("busy in done", 32'(busy), 32'd0);
        check("diff", 32'(diff), 32'(ed));
        check("bout", 32'(bout), 32'(eb));
        check("ovf", 32'(ovf), 32'(eo));
        check("zero", 32'(zero), 32'(ez));
        prev_diff = ed;
        prev_bout = eb;
        prev_ovf  = eo;
        prev_zero = ez;
        @(negedge clk);
        check("done pulse width", 32'(done), 32'd0);
        check("idle after done", 32'(busy), 32'd0);
        check("diff held", 32'(diff), 32'(ed));
        check("ovf held", 32'(ovf), 32'(eo));
        check("zero held", 32'(zero), 32'(ez));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        prev_diff = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;
        prev_zero = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(8'h05, 8'h03, 1'b0, -1, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, -1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, -1, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, -1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, -1, 1'b0);
        run_op(8'h2A, 8'h2A, 1'b0, -1, 1'b0);
        // Start while busy is ignored; next start follows right after done.
        run_op(8'h10, 8'h01, 1'b0, 2, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, -1, 1'b0);
        // Reset mid-operation discards the result.
        run_op(8'h55, 8'h11, 1'b0, 3, 1'b1);
        run_op(8'h09, 8'h04, 1'b0, -1, 1'b0);

        // Random operands, occasional ignored start pulses
        repeat (60) begin
            logic [Width-1:0] ra;
            logic [Width-1:0] rb;
            logic             rbin;
            int               inj;
            ra   = Width'($urandom);
            rb   = Width'($urandom);
            rbin = 1'($urandom_range(0, 1));
            inj  = int'($urandom_range(0, 15));
            run_op(ra, rb, rbin, inj, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; the subtract-direction counterpart to the team's ripple full-adder datapath.
- Latches operands A, B and a borrow-in on a start pulse.
- Resolves one difference bit per clock, LSB first, through a single full-subtractor cell and a registered borrow flip-flop.
- Presents the parallel difference plus status flags with a one-cycle done pulse; intended as the small-area arithmetic unit next to the adder blocks on the board.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, sampled with start
b  input  WIDTH  subtrahend, sampled with start
bin  input  1  borrow-in, sampled with start
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when results become valid
diff  output  WIDTH  difference a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow-out (1 = unsigned underflow)
ovf  output  1  signed two's-complement overflow
zero  output  1  diff == 0
d_bit  output  1  current serial difference bit, valid while busy

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy, done, diff, bout, ovf, zero and d_bit all go to 0; internal shift registers, borrow FF and counter are cleared.
  - Reset has priority over every other input, including mid-operation; a partial result is discarded and no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On start=1: load a into sa, b into sb, bin into the borrow FF; clear the result shift register; cnt=0; go to SHIFT.
  - The a[WIDTH-1] and b[WIDTH-1] sign bits are also captured at load for the overflow calculation.
- SHIFT (busy=1), every cycle:
  - d = sa[0] ^ sb[0] ^ br
  - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - d is shifted into the result register MSB, so after WIDTH shifts bit 0 is in the LSB.
  - sa and sb shift right by one; cnt increments.
  - d_bit shows the combinational d of the current cycle.
  - When cnt == WIDTH-1 (last bit), go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - diff = the assembled result; bout = final borrow FF.
  - ovf = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb).
  - zero = (diff == 0).
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge k; busy=1 for cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1, which is the same cycle diff, bout, ovf and zero update.
- Throughput: a new start is accepted at the earliest in the cycle after done (back-to-back period WIDTH+2).
- Result outputs hold their value from done until the next DONE state or reset. They do not change while a new operation is busy.
- start while busy or in DONE is ignored (not queued); operand input changes after load have no effect.
- bin=1 with a=b gives diff = all-ones and bout=1. Wrap-around is modulo 2^WIDTH, and no saturation is applied.
- zero is evaluated on the final diff only; the bin effect is included.

Test Plan:
- Reset, then a=0x05, b=0x03, bin=0, start pulse:
  - busy high exactly 8 cycles; done pulse in cycle 9 after start.
  - diff=0x02, bout=0, ovf=0, zero=0.
  - d_bit sequence LSB-first 0,1,0,0,0,0,0,0.
- a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0, zero=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
- a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, zero=0.
- a=0x2A, b=0x2A, bin=0 -> diff=0x00, zero=1, bout=0.
- Start 0x10-0x01. At busy cycle 3, change a/b and pulse start again:
  - Second start is ignored; result is diff=0x0F.
  - Exactly one done pulse is issued; the next start is accepted in the cycle after done.
- Start 0x55-0x11. Assert rst for one cycle at busy cycle 4:
  - All outputs are 0 the next cycle and no done pulse occurs.
  - A fresh start of 0x09-0x04 then yields diff=0x05.
